execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the in-order RV32IM core; sits between decode and MemoryStage.
//  Computes alu_out (RV32I ALU + M-extension) and registers reg_pc/rs2_data/mem_wen/wb_sel
//  for MemoryStage. MUL* complete in 1 cycle; DIV/REM use a 32-iteration divider.
//  Honours MemoryStage next_flg back-pressure; stalls decode via output_is_stall.
// PARAMETERS
//  DIV_ITERS   32   divider iterations (one quotient bit per cycle); fixed for XLEN=32
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  in_valid          in   1   decode presents a valid instruction
//  reg_pc            in   32  instruction PC
//  op1_data          in   32  ALU operand 1
//  op2_data          in   32  ALU operand 2
//  rs2_data          in   32  store data, passed through
//  exe_fun           in   5   ALU_* op code
//  mem_wen           in   5   MEN_* code, passed through
//  wb_sel            in   4   WB_* code, passed through
//  output_is_stall   out  1   decode must hold its outputs this cycle
//  mem_next_flg      in   1   MemoryStage next_flg: EX output regs may update
//  output_reg_pc     out  32  registered PC to MemoryStage
//  output_rs2_data   out  32  registered rs2_data
//  output_alu_out    out  32  registered result
//  output_mem_wen    out  5   registered mem_wen; MEN_X = bubble
//  output_wb_sel     out  4   registered wb_sel; WB_X = bubble
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_RUN, count=0, output_mem_wen=MEN_X, output_wb_sel=WB_X,
//   output_reg_pc/rs2_data/alu_out=0. Reset mid-division aborts; the op is lost.
//  Output regs load only on edges where mem_next_flg=1; otherwise they hold.
//  Loaded value: finished result if one exists this edge, else bubble (MEN_X/WB_X, data 0).
//  ALU codes: X=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SRL=7 SRA=8 SLT=9 SLTU=10 JALR=11
//   COPY1=12 MUL=13 MULH=14 MULHSU=15 MULHU=16 DIV=17 DIVU=18 REM=19 REMU=20.
//  Arithmetic: mod 2^32; shift amount op2[4:0]; SLT/SLTU yield 0/1.
//   JALR=(op1+op2)&~1; COPY1=op1; ALU_X=0.
//   MUL low 32 bits; MULH* upper 32 bits of the 64-bit product (signed/mixed/unsigned).
//  Divide special cases finish in 1 cycle, like single-cycle ops:
//   divisor 0: DIV/DIVU q=0xFFFFFFFF, REM/REMU r=dividend.
//   DIV/REM 0x80000000 / -1: q=0x80000000, r=0.
//  States:
//   S_RUN: if in_valid & mem_next_flg & non-special divide: latch |operands|, signs, op,
//    pc, rs2, mem_wen, wb_sel; count=0; ->S_DIV; load bubble.
//    Else if in_valid & mem_next_flg: load result (0 extra latency).
//    Else (!in_valid or !mem_next_flg): no accept; bubble if mem_next_flg.
//   S_DIV: one restoring step per edge, count++; after step DIV_ITERS-1 ->S_DONE.
//    Bubble loaded if mem_next_flg.
//   S_DONE: fix signs (DIV q negated if signs differ; REM r takes dividend sign).
//    If mem_next_flg: load result, ->S_RUN; else stay.
//  Latency: issue edge E0 -> quotient/remainder on outputs after E0+33 with no back-pressure.
//  output_is_stall = !mem_next_flg | (state!=S_RUN) | (S_RUN & in_valid & non-special div).
//  Decode's next instruction is accepted the edge after S_DONE drains.
//  in_valid=0 with mem_next_flg=1 in S_RUN: bubble loaded, no state change.
// STRUCTURE
//  Shared include core.v: ALU_*, MEN_*, WB_* constants (ALU_* codes added there).
//  Local: S_RUN/S_DIV/S_DONE state constants.
//  Sub-module div_unit: unsigned 32/32 restoring divider.
//   Ports: start, dividend, divisor -> busy, done, quotient, remainder.
//   Signs, special cases and all pipeline registers stay in execute_stage.
// TESTING
//  T1: ADD 0xFFFFFFFF+1, SRA 0x80000000>>4, mem_next_flg=1 -> alu_out 0x0, then 0xF8000000, one edge each.
//  T2: DIV -7/2 -> 0xFFFFFFFD after E0+33; REM -7/2 -> 0xFFFFFFFF; stall high E0..E0+33, bubbles in between.
//  T3: DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; each 1 cycle, no stall.
//  T4: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
//  T5: mem_next_flg low 5 cycles with a LW in outputs (also during S_DONE) -> outputs frozen, stall=1, no op lost or duplicated.
//  T6: rst_n low at count=10 of DIV -> outputs bubble immediately (async); S_RUN; next ADD after release correct.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared EX-stage types, op codes and single-cycle ALU helper for the RV32IM core.
package execute_stage_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned CNT_W     = $clog2(DIV_ITERS);
   localparam int unsigned ALU_W     = 5;
   localparam int unsigned MEN_W     = 5;
   localparam int unsigned WB_W      = 4;

   typedef enum logic [ALU_W-1:0] {
      ALU_X      = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB    = 5'd2,  ALU_AND   = 5'd3,
      ALU_OR     = 5'd4,  ALU_XOR   = 5'd5,  ALU_SLL    = 5'd6,  ALU_SRL   = 5'd7,
      ALU_SRA    = 5'd8,  ALU_SLT   = 5'd9,  ALU_SLTU   = 5'd10, ALU_JALR  = 5'd11,
      ALU_COPY1  = 5'd12, ALU_MUL   = 5'd13, ALU_MULH   = 5'd14, ALU_MULHSU = 5'd15,
      ALU_MULHU  = 5'd16, ALU_DIV   = 5'd17, ALU_DIVU   = 5'd18, ALU_REM   = 5'd19,
      ALU_REMU   = 5'd20
   } alu_op_e;

   localparam logic [MEN_W-1:0] MEN_X = 5'd0;
   localparam logic [WB_W-1:0]  WB_X  = 4'd0;

   typedef enum logic [1:0] {S_RUN = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} ex_state_e;

   typedef struct packed {
      logic [XLEN-1:0]  reg_pc;
      logic [XLEN-1:0]  rs2_data;
      logic [XLEN-1:0]  alu_out;
      logic [MEN_W-1:0] mem_wen;
      logic [WB_W-1:0]  wb_sel;
   } ex_mem_t;

   localparam ex_mem_t EX_BUBBLE = '{reg_pc: '0, rs2_data: '0, alu_out: '0,
                                     mem_wen: MEN_X, wb_sel: WB_X};

   // True when the op must go through the iterative divider (no shortcut result).
   function automatic logic is_long_div(input logic [ALU_W-1:0] op,
                                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic div_op, signed_op, ovf;
      div_op    = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
      signed_op = (op == ALU_DIV) || (op == ALU_REM);
      ovf       = signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      return div_op && (b != '0) && !ovf;
   endfunction

   // Single-cycle result; for divide ops only the shortcut (zero divisor / overflow) cases are valid.
   function automatic logic [XLEN-1:0] alu_single(input logic [ALU_W-1:0] op,
                                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] ss, su, uu;
      logic [4:0]        sh;
      sh = b[4:0];
      ss = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
      su = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{1'b0}}, b});
      uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      case (alu_op_e'(op))
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_XOR:    return a ^ b;
         ALU_SLL:    return a << sh;
         ALU_SRL:    return a >> sh;
         ALU_SRA:    return $unsigned($signed(a) >>> sh);
         ALU_SLT:    return {31'b0, ($signed(a) < $signed(b))};
         ALU_SLTU:   return {31'b0, (a < b)};
         ALU_JALR:   return (a + b) & ~32'h1;
         ALU_COPY1:  return a;
         ALU_MUL:    return ss[XLEN-1:0];
         ALU_MULH:   return ss[2*XLEN-1:XLEN];
         ALU_MULHSU: return su[2*XLEN-1:XLEN];
         ALU_MULHU:  return uu[2*XLEN-1:XLEN];
         ALU_DIV:    return (b == '0) ? '1 : a;
         ALU_DIVU:   return '1;
         ALU_REM:    return (b == '0) ? a : '0;
         ALU_REMU:   return a;
         default:    return '0;
      endcase
   endfunction

endpackage

// File: rtl/execute_stage_div_unit.sv
// Unsigned 32/32 restoring divider, one quotient bit per clock.
module div_unit
   import execute_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;
   logic [XLEN:0]    shifted_c, diff_c;
   logic             fits_c;

   // Trial subtraction of the divisor from the partial remainder.
   always_comb begin
      shifted_c = {rem_q, quo_q[XLEN-1]};
      diff_c    = shifted_c - {1'b0, dvs_q};
      fits_c    = (shifted_c >= {1'b0, dvs_q});
   end

   // Load on start, then shift in one quotient bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         rem_q <= fits_c ? diff_c[XLEN-1:0] : shifted_c[XLEN-1:0];
         quo_q <= {quo_q[XLEN-2:0], fits_c};
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU/MUL, iterative DIV/REM, registered handoff to MemoryStage.
module execute_stage
   import execute_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [XLEN-1:0]  reg_pc,
   input  logic [XLEN-1:0]  op1_data,
   input  logic [XLEN-1:0]  op2_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [ALU_W-1:0] exe_fun,
   input  logic [MEN_W-1:0] mem_wen,
   input  logic [WB_W-1:0]  wb_sel,
   output logic             output_is_stall,
   input  logic             mem_next_flg,
   output logic [XLEN-1:0]  output_reg_pc,
   output logic [XLEN-1:0]  output_rs2_data,
   output logic [XLEN-1:0]  output_alu_out,
   output logic [MEN_W-1:0] output_mem_wen,
   output logic [WB_W-1:0]  output_wb_sel
);

   ex_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_div_c, div_start_c, fin_valid_c;
   logic             signed_op_c, neg_res_c, is_quot_c;
   logic [XLEN-1:0]  abs_a_c, abs_b_c, div_res_c;
   ex_mem_t          fin_c, out_q;

   // Held copy of the instruction in the divider.
   logic [XLEN-1:0]  pc_q, rs2_q;
   logic [MEN_W-1:0] wen_q;
   logic [WB_W-1:0]  wb_q;
   logic             neg_res_q, is_quot_q;

   logic             div_busy, div_done;
   logic [XLEN-1:0]  div_quo, div_rem;

   // Operand magnitudes, result-sign rule and the sign-fixed divider result.
   always_comb begin
      long_div_c  = in_valid && is_long_div(exe_fun, op1_data, op2_data);
      signed_op_c = (exe_fun == ALU_DIV) || (exe_fun == ALU_REM);
      is_quot_c   = (exe_fun == ALU_DIV) || (exe_fun == ALU_DIVU);
      abs_a_c     = (signed_op_c && op1_data[XLEN-1]) ? -op1_data : op1_data;
      abs_b_c     = (signed_op_c && op2_data[XLEN-1]) ? -op2_data : op2_data;
      neg_res_c   = signed_op_c && (is_quot_c ? (op1_data[XLEN-1] ^ op2_data[XLEN-1])
                                              : op1_data[XLEN-1]);
      div_res_c   = is_quot_q ? div_quo : div_rem;
      if (neg_res_q) div_res_c = -div_res_c;
   end

   // Next-state logic and the value MemoryStage would receive this edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_start_c = 1'b0;
      fin_valid_c = 1'b0;
      fin_c       = EX_BUBBLE;
      case (state_q)
         S_RUN: begin
            if (in_valid && mem_next_flg) begin
               if (long_div_c) begin
                  div_start_c = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_DIV;
               end else begin
                  fin_valid_c    = 1'b1;
                  fin_c.reg_pc   = reg_pc;
                  fin_c.rs2_data = rs2_data;
                  fin_c.alu_out  = alu_single(exe_fun, op1_data, op2_data);
                  fin_c.mem_wen  = mem_wen;
                  fin_c.wb_sel   = wb_sel;
               end
            end
         end
         S_DIV: begin
            if (div_busy) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (mem_next_flg && div_done) begin
               fin_valid_c    = 1'b1;
               fin_c.reg_pc   = pc_q;
               fin_c.rs2_data = rs2_q;
               fin_c.alu_out  = div_res_c;
               fin_c.mem_wen  = wen_q;
               fin_c.wb_sel   = wb_q;
               state_d        = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // State and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the pass-through fields of an instruction entering the divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         rs2_q     <= '0;
         wen_q     <= MEN_X;
         wb_q      <= WB_X;
         neg_res_q <= 1'b0;
         is_quot_q <= 1'b0;
      end else if (div_start_c) begin
         pc_q      <= reg_pc;
         rs2_q     <= rs2_data;
         wen_q     <= mem_wen;
         wb_q      <= wb_sel;
         neg_res_q <= neg_res_c;
         is_quot_q <= is_quot_c;
      end
   end

   // Output registers advance only when MemoryStage accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            out_q <= EX_BUBBLE;
      else if (mem_next_flg) out_q <= fin_valid_c ? fin_c : EX_BUBBLE;
   end

   div_unit u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start_c),
      .dividend  (abs_a_c),
      .divisor   (abs_b_c),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign output_is_stall = !mem_next_flg || (state_q != S_RUN) || long_div_c;
   assign output_reg_pc   = out_q.reg_pc;
   assign output_rs2_data = out_q.rs2_data;
   assign output_alu_out  = out_q.alu_out;
   assign output_mem_wen  = out_q.mem_wen;
   assign output_wb_sel   = out_q.wb_sel;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

   localparam int OP_ADD = 1, OP_SRA = 8, OP_MULH = 14, OP_MULHSU = 15, OP_MULHU = 16;
   localparam int OP_DIV = 17, OP_DIVU = 18, OP_REM = 19, OP_REMU = 20;
   localparam logic [104:0] BUBBLE = '0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] reg_pc, op1_data, op2_data, rs2_data;
   logic [4:0]  exe_fun, mem_wen;
   logic [3:0]  wb_sel;
   logic        output_is_stall;
   logic        mem_next_flg;
   logic [31:0] output_reg_pc, output_rs2_data, output_alu_out;
   logic [4:0]  output_mem_wen;
   logic [3:0]  output_wb_sel;

   int n_tests = 0;
   int n_fail  = 0;

   execute_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .reg_pc          (reg_pc),
      .op1_data        (op1_data),
      .op2_data        (op2_data),
      .rs2_data        (rs2_data),
      .exe_fun         (exe_fun),
      .mem_wen         (mem_wen),
      .wb_sel          (wb_sel),
      .output_is_stall (output_is_stall),
      .mem_next_flg    (mem_next_flg),
      .output_reg_pc   (output_reg_pc),
      .output_rs2_data (output_rs2_data),
      .output_alu_out  (output_alu_out),
      .output_mem_wen  (output_mem_wen),
      .output_wb_sel   (output_wb_sel)
   );

   always #5 clk = ~clk;

   // Reference: RV32IM result computed with plain 64-bit integer arithmetic.
   function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      pu = ua * ub;
      case (op)
         1:  return a + b;
         2:  return a - b;
         3:  return a & b;
         4:  return a | b;
         5:  return a ^ b;
         6:  return a << b[4:0];
         7:  return a >> b[4:0];
         8:  return 32'(sa >>> b[4:0]);
         9:  return (sa < sb) ? 32'd1 : 32'd0;
         10: return (ua < ub) ? 32'd1 : 32'd0;
         11: return (a + b) & 32'hFFFF_FFFE;
         12: return a;
         13: return 32'(sa * sb);
         14: return 32'((sa * sb) >>> 32);
         15: return 32'((sa * longint'(ub)) >>> 32);
         16: return 32'(pu >> 32);
         17: return (b == 0) ? 32'hFFFF_FFFF :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
         18: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         19: return (b == 0) ? a :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
         20: return (b == 0) ? a : 32'(ua % ub);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [104:0] obs();
      return {output_reg_pc, output_rs2_data, output_alu_out, output_mem_wen, output_wb_sel};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      exe_fun  = 5'(op);
      op1_data = a;
      op2_data = b;
      reg_pc   = $urandom & 32'hFFFF_FFFC;
      rs2_data = $urandom;
      mem_wen  = 5'($urandom_range(1, 31));
      wb_sel   = 4'($urandom_range(1, 15));
   endtask

   function automatic logic [104:0] expect_now(input int op);
      return {reg_pc, rs2_data, model(op, op1_data, op2_data), mem_wen, wb_sel};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; mem_next_flg = 1'b1;
      drive(OP_ADD, 32'd1, 32'd2); in_valid = 1'b0;
      #3;
      n_tests++;
      if (obs() !== BUBBLE) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), BUBBLE); end
      step(); step();
      rst_n = 1'b1;
      step();
      n_tests++;
      if (obs() !== BUBBLE || output_is_stall !== 1'b0) begin
         n_fail++; $display("FAIL idle_bubble: got %h stall %b want %h stall 0", obs(), output_is_stall, BUBBLE);
      end
   endtask

   task automatic test_alu_t1();
      logic [104:0] e;
      mem_next_flg = 1'b1;
      drive(OP_ADD, 32'hFFFF_FFFF, 32'd1); e = expect_now(OP_ADD);
      step();
      n_tests++;
      if (obs() !== e || output_alu_out !== 32'h0) begin n_fail++; $display("FAIL t1_add: got %h want %h", obs(), e); end
      drive(OP_SRA, 32'h8000_0000, 32'd4); e = expect_now(OP_SRA);
      step();
      n_tests++;
      if (obs() !== e || output_alu_out !== 32'hF800_0000) begin n_fail++; $display("FAIL t1_sra: got %h want %h", obs(), e); end
   endtask

   task automatic test_random_alu();
      logic [104:0] e;
      logic [31:0]  a, b;
      int           op;
      mem_next_flg = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 16);
         a  = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
         b  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
         drive(op, a, b); e = expect_now(op);
         #1;
         n_tests++;
         if (output_is_stall !== 1'b0) begin n_fail++; $display("FAIL rand_stall op %0d: got %b want 0", op, output_is_stall); end
         step();
         n_tests++;
         if (obs() !== e) begin n_fail++; $display("FAIL rand_alu op %0d a %h b %h: got %h want %h", op, a, b, obs(), e); end
      end
   endtask

   // Issue a long divide, check 33 cycles of stall/bubbles, then the result and release.
   task automatic run_long_div(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [104:0] e;
      int           bad;
      mem_next_flg = 1'b1;
      drive(op, a, b); e = expect_now(op);
      #1;
      n_tests++;
      if (output_is_stall !== 1'b1) begin n_fail++; $display("FAIL div_issue_stall op %0d: got %b want 1", op, output_is_stall); end
      step();
      in_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < 33; k++) begin
         if (obs() !== BUBBLE || output_is_stall !== 1'b1) bad++;
         if (k < 32) step();
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL div_busy op %0d: got %0d bad cycles want 0", op, bad); end
      step();
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL div_result op %0d a %h b %h: got %h want %h", op, a, b, obs(), e); end
      n_tests++;
      if (output_is_stall !== 1'b0) begin n_fail++; $display("FAIL div_release op %0d: got %b want 0", op, output_is_stall); end
   endtask

   task automatic test_div_t2();
      run_long_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      n_tests++;
      if (output_alu_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL t2_div: got %h want fffffffd", output_alu_out); end
      run_long_div(OP_REM, 32'hFFFF_FFF9, 32'd2);
      n_tests++;
      if (output_alu_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t2_rem: got %h want ffffffff", output_alu_out); end
      for (int i = 0; i < 6; i++)
         run_long_div($urandom_range(OP_DIV, OP_REMU), $urandom, (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
   endtask

   task automatic test_div_special_t3();
      logic [104:0] e;
      int ops[4]           = '{OP_DIVU, OP_REM, OP_DIV, OP_REMU};
      logic [31:0] as[4]   = '{32'h1234_5678, 32'd5, 32'h8000_0000, 32'hDEAD_BEEF};
      logic [31:0] bs[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] want[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hDEAD_BEEF};
      mem_next_flg = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], as[i], bs[i]); e = expect_now(ops[i]);
         #1;
         n_tests++;
         if (output_is_stall !== 1'b0) begin n_fail++; $display("FAIL t3_stall %0d: got %b want 0", i, output_is_stall); end
         step();
         n_tests++;
         if (obs() !== e || output_alu_out !== want[i]) begin n_fail++; $display("FAIL t3_special %0d: got %h want %h", i, obs(), e); end
      end
   endtask

   task automatic test_mulh_t4();
      int ops[3]           = '{OP_MULH, OP_MULHU, OP_MULHSU};
      logic [31:0] as[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
      logic [31:0] want[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      mem_next_flg = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], as[i], bs[i]);
         step();
         n_tests++;
         if (output_alu_out !== want[i]) begin n_fail++; $display("FAIL t4_mulh %0d: got %h want %h", i, output_alu_out, want[i]); end
      end
   endtask

   task automatic test_backpressure_t5();
      logic [104:0] e_lw, e_nx, e_div;
      int bad;
      mem_next_flg = 1'b1;
      drive(OP_ADD, 32'h0000_1000, 32'd4); e_lw = expect_now(OP_ADD);
      step();
      n_tests++;
      if (obs() !== e_lw) begin n_fail++; $display("FAIL t5_lw: got %h want %h", obs(), e_lw); end
      mem_next_flg = 1'b0;
      drive(OP_ADD, 32'd40, 32'd2); e_nx = expect_now(OP_ADD);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1; if (output_is_stall !== 1'b1) bad++;
         step(); if (obs() !== e_lw) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL t5_freeze: got %0d bad checks want 0", bad); end
      mem_next_flg = 1'b1;
      step();
      n_tests++;
      if (obs() !== e_nx) begin n_fail++; $display("FAIL t5_not_lost: got %h want %h", obs(), e_nx); end
      in_valid = 1'b0;
      step();
      n_tests++;
      if (obs() !== BUBBLE) begin n_fail++; $display("FAIL t5_not_dup: got %h want %h", obs(), BUBBLE); end
      drive(OP_DIVU, 32'd100, 32'd7); e_div = expect_now(OP_DIVU);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 32; k++) step();
      mem_next_flg = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (obs() !== BUBBLE || output_is_stall !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL t5_done_hold: got %0d bad cycles want 0", bad); end
      mem_next_flg = 1'b1;
      step();
      n_tests++;
      if (obs() !== e_div || output_alu_out !== 32'd14) begin n_fail++; $display("FAIL t5_done_drain: got %h want %h", obs(), e_div); end
      step();
      n_tests++;
      if (obs() !== BUBBLE) begin n_fail++; $display("FAIL t5_done_once: got %h want %h", obs(), BUBBLE); end
   endtask

   task automatic test_reset_mid_div_t6();
      logic [104:0] e;
      int bad;
      mem_next_flg = 1'b1;
      drive(OP_DIV, 32'd1000, 32'd3);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) step();
      n_tests++;
      if (output_is_stall !== 1'b1) begin n_fail++; $display("FAIL t6_busy: got %b want 1", output_is_stall); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs() !== BUBBLE || output_is_stall !== 1'b0) begin
         n_fail++; $display("FAIL t6_async: got %h stall %b want %h stall 0", obs(), output_is_stall, BUBBLE);
      end
      step(); step();
      rst_n = 1'b1;
      drive(OP_ADD, 32'd123, 32'd456); e = expect_now(OP_ADD);
      step();
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL t6_after_reset: got %h want %h", obs(), e); end
      in_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (obs() !== BUBBLE || output_is_stall !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL t6_aborted: got %0d bad cycles want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_alu_t1();
      test_random_alu();
      test_div_t2();
      test_div_special_t3();
      test_mulh_t4();
      test_backpressure_t5();
      test_reset_mid_div_t6();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
